tcp_vlg_ka_mc: RTL and testbench

Multi-channel TCP keep-alive supervisor. It tracks up to `CHANNELS` connections at once, each with its own idle timer, probe-interval timer and probe-retry counter. It arbitrates probe requests round-robin onto a single request/acknowledge port to the TCP engine, and raises a per-channel disconnect when a peer stays silent through `TRIES` probes. It sits between the RX segment classifier (which supplies a channel hit) and the TCP engine TX scheduler.

---
 rtl/tcp_vlg_ka_mc.sv | 192 +++++++++++++++++++
 tb/tb_tcp_vlg_ka_mc.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_vlg_ka_mc.sv
// Multi-channel TCP keep-alive supervisor: per-channel idle/probe FSMs, round-robin probe arbiter.
// Optional feature macro TCP_KA_STATS_EN adds the saturating ka_probes accepted-probe counter.
module tcp_vlg_ka_mc #(
  parameter int CHANNELS       = 4,
  parameter int IDLE_TICKS     = 600000000,
  parameter int INTERVAL_TICKS = 125000000,
  parameter int TRIES          = 5,
  localparam int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] connected,
  input  logic [CHANNELS-1:0] ka_en,
  input  logic                rx_val,
  input  logic [CH_W-1:0]     rx_ch,
  output logic                ka_req,
  output logic [CH_W-1:0]     ka_ch,
  input  logic                ka_ack,
`ifdef TCP_KA_STATS_EN
  output logic [15:0]         ka_probes,
`endif
  output logic [CHANNELS-1:0] dcn
);

  localparam int TMR_MAX = (IDLE_TICKS > INTERVAL_TICKS) ? IDLE_TICKS : INTERVAL_TICKS;
  localparam int TMR_W   = $clog2(TMR_MAX);
  localparam int TR_W    = $clog2(TRIES + 1);

  localparam logic [TMR_W-1:0] IDLE_LAST = TMR_W'(IDLE_TICKS - 1);
  localparam logic [TMR_W-1:0] INTV_LAST = TMR_W'(INTERVAL_TICKS - 1);
  localparam logic [TR_W-1:0]  TRIES_MAX = TR_W'(TRIES);

  typedef enum logic [2:0] {ST_OFF, ST_IDLE, ST_PEND, ST_WAIT, ST_DCN} state_t;

  state_t             state_q [CHANNELS];
  state_t             state_d [CHANNELS];
  logic [TMR_W-1:0]   timer_q [CHANNELS];
  logic [TMR_W-1:0]   timer_d [CHANNELS];
  logic [TR_W-1:0]    tries_q [CHANNELS];
  logic [TR_W-1:0]    tries_d [CHANNELS];

  logic [CHANNELS-1:0]   rx_hit;
  logic [CHANNELS-1:0]   acc_hit;
  logic [CHANNELS-1:0]   pend;
  logic                  accept;
  logic [CH_W-1:0]       ptr_q;
  logic [2*CHANNELS-1:0] pend_rot;
  logic                  pick_vld;
  logic [CH_W-1:0]       pick_ch;

  assign accept = ka_req && ka_ack;

  always_comb begin
    rx_hit  = '0;
    acc_hit = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      rx_hit[c]  = rx_val && (rx_ch == CH_W'(c));
      acc_hit[c] = accept && (ka_ch == CH_W'(c));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= ST_OFF;
        timer_q[c] <= '0;
        tries_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        timer_q[c] <= timer_d[c];
        tries_q[c] <= tries_d[c];
      end
    end
  end

  // Priority per channel: OFF condition, then RX hit, then grant/expiry.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c] = state_q[c];
      timer_d[c] = timer_q[c];
      tries_d[c] = tries_q[c];
      if (!(connected[c] && ka_en[c])) begin
        state_d[c] = ST_OFF;
        timer_d[c] = '0;
        tries_d[c] = '0;
      end else begin
        case (state_q[c])
          ST_OFF: begin
            state_d[c] = ST_IDLE;
            timer_d[c] = '0;
            tries_d[c] = '0;
          end
          ST_IDLE: begin
            if (rx_hit[c]) begin
              timer_d[c] = '0;
            end else if (timer_q[c] == IDLE_LAST) begin
              state_d[c] = ST_PEND;
              timer_d[c] = '0;
              tries_d[c] = '0;
            end else begin
              timer_d[c] = timer_q[c] + 1'b1;
            end
          end
          ST_PEND: begin
            if (rx_hit[c]) begin
              state_d[c] = ST_IDLE;
              timer_d[c] = '0;
              tries_d[c] = '0;
            end else if (acc_hit[c]) begin
              state_d[c] = ST_WAIT;
              timer_d[c] = '0;
              tries_d[c] = tries_q[c] + 1'b1;
            end
          end
          ST_WAIT: begin
            if (rx_hit[c]) begin
              state_d[c] = ST_IDLE;
              timer_d[c] = '0;
              tries_d[c] = '0;
            end else if (timer_q[c] == INTV_LAST) begin
              state_d[c] = (tries_q[c] == TRIES_MAX) ? ST_DCN : ST_PEND;
              timer_d[c] = '0;
            end else begin
              timer_d[c] = timer_q[c] + 1'b1;
            end
          end
          ST_DCN: begin
            state_d[c] = ST_DCN;
          end
          default: begin
            state_d[c] = ST_OFF;
            timer_d[c] = '0;
            tries_d[c] = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    dcn  = '0;
    pend = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      dcn[c]  = (state_q[c] == ST_DCN);
      pend[c] = (state_q[c] == ST_PEND);
    end
  end

  // Rotate pending vector so bit 0 is the current priority holder.
  assign pend_rot = {pend, pend} >> ptr_q;

  always_comb begin
    pick_vld = 1'b0;
    pick_ch  = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (pend_rot[i]) begin
        pick_vld = 1'b1;
        pick_ch  = CH_W'((int'(ptr_q) + i) % CHANNELS);
      end
    end
  end

  // A raised request is held untouched until acknowledged, even if its channel left PEND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ka_req <= 1'b0;
      ka_ch  <= '0;
      ptr_q  <= '0;
    end else if (ka_req) begin
      if (ka_ack) begin
        ka_req <= 1'b0;
        ptr_q  <= (ka_ch == CH_W'(CHANNELS - 1)) ? '0 : ka_ch + 1'b1;
      end
    end else if (pick_vld) begin
      ka_req <= 1'b1;
      ka_ch  <= pick_ch;
    end
  end

`ifdef TCP_KA_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ka_probes <= '0;
    end else if (accept && (ka_probes != 16'hFFFF)) begin
      ka_probes <= ka_probes + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tcp_vlg_ka_mc.sv
// Bench for tcp_vlg_ka_mc: directed scenarios plus random traffic against a countdown reference model.
`timescale 1ns/1ps
module tb_tcp_vlg_ka_mc;
  localparam int CH = 2, IDLE = 20, INTV = 8, TR = 3;
  localparam int M_OFF = 0, M_IDLE = 1, M_PEND = 2, M_WAIT = 3, M_DCN = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] connected = '0;
  logic [CH-1:0] ka_en = '0;
  logic          rx_val = 1'b0;
  logic [0:0]    rx_ch = '0;
  logic          ka_req;
  logic [0:0]    ka_ch;
  logic          ka_ack = 1'b0;
  logic [CH-1:0] dcn;
`ifdef TCP_KA_STATS_EN
  logic [15:0]   ka_probes;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model: phase, cycles left before the phase's deadline, probes sent.
  int ph [CH];
  int left [CH];
  int sent [CH];
  int m_req, m_ch, m_ptr, m_cnt;

  tcp_vlg_ka_mc #(.CHANNELS(CH), .IDLE_TICKS(IDLE), .INTERVAL_TICKS(INTV), .TRIES(TR)) dut (
    .clk(clk), .rst_n(rst_n), .connected(connected), .ka_en(ka_en),
    .rx_val(rx_val), .rx_ch(rx_ch), .ka_req(ka_req), .ka_ch(ka_ch), .ka_ack(ka_ack),
`ifdef TCP_KA_STATS_EN
    .ka_probes(ka_probes),
`endif
    .dcn(dcn)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      ph[c] = M_OFF; left[c] = 0; sent[c] = 0;
    end
    m_req = 0; m_ch = 0; m_ptr = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    int  nph [CH];
    int  nleft [CH];
    int  nsent [CH];
    bit  hit, acc, found;
    for (int c = 0; c < CH; c++) begin
      nph[c] = ph[c]; nleft[c] = left[c]; nsent[c] = sent[c];
      hit = rx_val && (int'(rx_ch) == c);
      acc = (m_req == 1) && ka_ack && (m_ch == c);
      if (!(connected[c] && ka_en[c])) begin
        nph[c] = M_OFF; nsent[c] = 0;
      end else if (ph[c] == M_OFF) begin
        nph[c] = M_IDLE; nleft[c] = IDLE;
      end else if (hit && (ph[c] == M_IDLE || ph[c] == M_PEND || ph[c] == M_WAIT)) begin
        nph[c] = M_IDLE; nleft[c] = IDLE; nsent[c] = 0;
      end else if (ph[c] == M_IDLE) begin
        nleft[c] = left[c] - 1;
        if (nleft[c] == 0) begin nph[c] = M_PEND; nsent[c] = 0; end
      end else if (ph[c] == M_PEND && acc) begin
        nph[c] = M_WAIT; nleft[c] = INTV; nsent[c] = sent[c] + 1;
      end else if (ph[c] == M_WAIT) begin
        nleft[c] = left[c] - 1;
        if (nleft[c] == 0) nph[c] = (sent[c] == TR) ? M_DCN : M_PEND;
      end
    end
    if (m_req == 1) begin
      if (ka_ack) begin
        m_req = 0;
        m_ptr = (m_ch + 1) % CH;
        if (m_cnt < 65535) m_cnt++;
      end
    end else begin
      found = 0;
      for (int i = 0; i < CH; i++) begin
        if (!found && ph[(m_ptr + i) % CH] == M_PEND) begin
          found = 1; m_req = 1; m_ch = (m_ptr + i) % CH;
        end
      end
    end
    for (int c = 0; c < CH; c++) begin
      ph[c] = nph[c]; left[c] = nleft[c]; sent[c] = nsent[c];
    end
  endtask

  task automatic compare_all();
    logic [CH-1:0] edcn;
    for (int c = 0; c < CH; c++) edcn[c] = (ph[c] == M_DCN);
    chk("ka_req", 32'(ka_req), 32'(m_req));
    chk("ka_ch", 32'(ka_ch), 32'(m_ch));
    chk("dcn", 32'(dcn), 32'(edcn));
`ifdef TCP_KA_STATS_EN
    chk("ka_probes", 32'(ka_probes), 32'(m_cnt));
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  // Reset is asserted mid-cycle so the outputs must clear without a clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_async_req", 32'(ka_req), 32'd0);
    chk("rst_async_ch", 32'(ka_ch), 32'd0);
    chk("rst_async_dcn", 32'(dcn), 32'd0);
    connected = '0; ka_en = '0; rx_val = 1'b0; rx_ch = '0; ka_ack = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int rise_at [3];
    int nrise, dcn_at, seen, prev;
    model_reset();
    #1;
    chk("reset_req", 32'(ka_req), 32'd0);
    chk("reset_ch", 32'(ka_ch), 32'd0);
    chk("reset_dcn", 32'(dcn), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Silent ch0 with ack tied high: three probes then disconnect.
    connected = 2'b01; ka_en = 2'b11; ka_ack = 1'b1;
    nrise = 0; dcn_at = -1; prev = 0;
    for (int n = 1; n <= 60; n++) begin
      cyc();
      if (ka_req && !prev && nrise < 3) begin rise_at[nrise] = n; nrise++; end
      if (dcn[0] && dcn_at < 0) dcn_at = n;
      prev = ka_req;
    end
    chk("s1_rises", nrise, 3);
    chk("s1_rise0", rise_at[0], 22);
    chk("s1_rise1", rise_at[1], 32);
    chk("s1_rise2", rise_at[2], 42);
    chk("s1_dcn_at", dcn_at, 51);
    chk("s1_dcn1", 32'(dcn[1]), 32'd0);

    // Drop connection while in DCN: dcn falls on the next edge.
    connected = 2'b00;
    cyc();
    chk("s1_dcn_fall", 32'(dcn[0]), 32'd0);

    // Regular RX traffic keeps the channel from probing.
    do_reset();
    connected = 2'b01; ka_en = 2'b11; ka_ack = 1'b1;
    seen = 0;
    for (int n = 1; n <= 500; n++) begin
      rx_val = (n % 10 == 0); rx_ch = 1'b0;
      cyc();
      if (ka_req) seen = 1;
    end
    rx_val = 1'b0;
    chk("s2_no_req", seen, 0);
    chk("s2_no_dcn", 32'(dcn), 32'd0);

    // Both channels expire together; stalled ack must hold the request stable.
    do_reset();
    connected = 2'b11; ka_en = 2'b11; ka_ack = 1'b0;
    for (int n = 0; n < 40 && !ka_req; n++) cyc();
    chk("s3_req_rise", 32'(ka_req), 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk("s3_hold_req", 32'(ka_req), 32'd1);
      chk("s3_hold_ch", 32'(ka_ch), 32'd0);
      if (k < 4) cyc();
    end
    ka_ack = 1'b1;
    cyc();
    ka_ack = 1'b0;
    chk("s3_gap", 32'(ka_req), 32'd0);
    cyc();
    chk("s3_next_req", 32'(ka_req), 32'd1);
    chk("s3_next_ch", 32'(ka_ch), 32'd1);

    // Reset with a live request.
    do_reset();

    // RX hit in WAIT after two probes restarts the whole probe sequence.
    connected = 2'b01; ka_en = 2'b11; ka_ack = 1'b1;
    for (int n = 1; n <= 34; n++) cyc();
    rx_val = 1'b1; rx_ch = 1'b0;
    cyc();
    rx_val = 1'b0;
    nrise = 0; dcn_at = -1; prev = 0; rise_at[0] = -1;
    for (int n = 1; n <= 60; n++) begin
      cyc();
      if (ka_req && !prev) begin
        if (nrise == 0) rise_at[0] = n;
        if (dcn_at < 0) nrise++;
      end
      if (dcn[0] && dcn_at < 0) dcn_at = n;
      prev = ka_req;
    end
    chk("s4_fresh_rise", rise_at[0], 21);
    chk("s4_probes_before_dcn", nrise, 3);
    chk("s4_dcn_at", dcn_at, 50);

    // Connection drop mid-WAIT: channel goes quiet, no disconnect.
    do_reset();
    connected = 2'b01; ka_en = 2'b11; ka_ack = 1'b1;
    for (int n = 1; n <= 26; n++) cyc();
    connected = 2'b00;
    cyc();
    chk("s5_dcn_off", 32'(dcn), 32'd0);
    seen = 0;
    for (int n = 0; n < 30; n++) begin
      cyc();
      if (ka_req || dcn != 0) seen = 1;
    end
    chk("s5_quiet", seen, 0);

    // Randomised traffic against the model.
    do_reset();
    connected = 2'b11; ka_en = 2'b11;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 199) == 0) connected[c] = ~connected[c];
        if ($urandom_range(0, 299) == 0) ka_en[c] = ~ka_en[c];
      end
      rx_val = ($urandom_range(0, 39) == 0);
      rx_ch  = 1'($urandom_range(0, 1));
      ka_ack = ($urandom_range(0, 2) != 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
